// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812-style NRZ line receiver producing 24-bit pixels, latch-gap and error pulses.
// Defining WS2812_RX_FORWARD_EN builds the downstream pass-through on dout; otherwise dout is 0.
module ws2812_rx #(
    parameter int CLK_SPEED = 25_000_000,
    parameter int LED_CNT   = 3
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             din,
    output logic [23:0]                                      pixel_o,
    output logic [((LED_CNT > 1) ? $clog2(LED_CNT) : 1)-1:0] pixel_idx_o,
    output logic                                             pixel_valid_o,
    output logic                                             latch_o,
    output logic                                             error_o,
    output logic                                             dout
);
    // Scaling by an integer before dividing keeps the nominal counts exact in floating point.
    localparam int COUNT_TH    = $rtoi(CLK_SPEED * 6.0 / 1.0e7);
    localparam int COUNT_MAX   = $rtoi(CLK_SPEED * 2.0 / 1.0e6);
    localparam int COUNT_LATCH = $rtoi(CLK_SPEED * 5.0 / 1.0e5);

    localparam int IDX_W  = (LED_CNT > 1) ? $clog2(LED_CNT) : 1;
    localparam int PCNT_W = $clog2(LED_CNT + 1);
    localparam int HCNT_W = $clog2(COUNT_MAX + 1);
    localparam int LCNT_W = $clog2(COUNT_LATCH + 1);

    localparam logic [HCNT_W-1:0] HCNT_TH    = HCNT_W'(COUNT_TH);
    localparam logic [HCNT_W-1:0] HCNT_MAX   = HCNT_W'(COUNT_MAX);
    localparam logic [LCNT_W-1:0] LCNT_LATCH = LCNT_W'(COUNT_LATCH);
    localparam logic [PCNT_W-1:0] PIX_LIMIT  = PCNT_W'(LED_CNT);
    localparam logic [4:0]        LAST_BIT   = 5'd23;

    typedef enum logic [1:0] {
        ST_WAIT_GAP = 2'd0,
        ST_IDLE     = 2'd1,
        ST_HIGH     = 2'd2,
        ST_LOW      = 2'd3
    } state_t;

    state_t              state_r;
    logic                sync1_r;
    logic                s_r;
    logic [HCNT_W-1:0]   hcnt_r;
    logic [LCNT_W-1:0]   lcnt_r;
    logic [4:0]          bitcnt_r;
    logic [PCNT_W-1:0]   pixcnt_r;
    logic [23:0]         shift_r;
    logic [23:0]         pixel_r;
    logic [IDX_W-1:0]    pixel_idx_r;
    logic                pixel_valid_r;
    logic                latch_r;
    logic                error_r;

    logic [HCNT_W-1:0]   hcnt_inc_s;
    logic [LCNT_W-1:0]   lcnt_inc_s;
    logic                bit_s;
    logic                last_bit_s;
    logic [23:0]         word_s;
    logic                hi_err_s;
    logic                gap_end_s;

    // Two-flop synchronizer for the asynchronous line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            s_r     <= 1'b0;
        end else begin
            sync1_r <= din;
            s_r     <= sync1_r;
        end
    end

    // Next counter values, bit decision and the pixel word with the current bit inserted.
    always_comb begin
        hcnt_inc_s       = hcnt_r + HCNT_W'(1);
        lcnt_inc_s       = lcnt_r + LCNT_W'(1);
        bit_s            = (hcnt_r >= HCNT_TH);
        last_bit_s       = (bitcnt_r == LAST_BIT);
        word_s           = shift_r;
        word_s[bitcnt_r] = bit_s;
        hi_err_s         = (state_r == ST_HIGH) && s_r && (hcnt_inc_s == HCNT_MAX);
        gap_end_s        = (state_r == ST_LOW) && !s_r && (lcnt_inc_s == LCNT_LATCH);
    end

    // Receive FSM with registered pixel, latch and error outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_WAIT_GAP;
            hcnt_r        <= '0;
            lcnt_r        <= '0;
            bitcnt_r      <= 5'd0;
            pixcnt_r      <= '0;
            shift_r       <= 24'd0;
            pixel_r       <= 24'd0;
            pixel_idx_r   <= '0;
            pixel_valid_r <= 1'b0;
            latch_r       <= 1'b0;
            error_r       <= 1'b0;
        end else begin
            pixel_valid_r <= 1'b0;
            latch_r       <= 1'b0;
            error_r       <= 1'b0;
            case (state_r)
                ST_WAIT_GAP: begin
                    if (s_r) begin
                        lcnt_r <= '0;
                    end else if (lcnt_inc_s == LCNT_LATCH) begin
                        lcnt_r  <= '0;
                        state_r <= ST_IDLE;
                    end else begin
                        lcnt_r <= lcnt_inc_s;
                    end
                end
                ST_IDLE: begin
                    if (s_r) begin
                        hcnt_r  <= HCNT_W'(1);
                        state_r <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (hi_err_s) begin
                        // Overlong high: drop the partial pixel and resynchronise on a full gap.
                        error_r  <= 1'b1;
                        hcnt_r   <= '0;
                        lcnt_r   <= '0;
                        bitcnt_r <= 5'd0;
                        pixcnt_r <= '0;
                        shift_r  <= 24'd0;
                        state_r  <= ST_WAIT_GAP;
                    end else if (s_r) begin
                        hcnt_r <= hcnt_inc_s;
                    end else begin
                        lcnt_r  <= LCNT_W'(1);
                        state_r <= ST_LOW;
                        if (last_bit_s) begin
                            bitcnt_r <= 5'd0;
                            shift_r  <= 24'd0;
                            if (pixcnt_r < PIX_LIMIT) begin
                                pixel_r       <= word_s;
                                pixel_idx_r   <= pixcnt_r[IDX_W-1:0];
                                pixel_valid_r <= 1'b1;
                                pixcnt_r      <= pixcnt_r + PCNT_W'(1);
                            end
                        end else begin
                            shift_r  <= word_s;
                            bitcnt_r <= bitcnt_r + 5'd1;
                        end
                    end
                end
                ST_LOW: begin
                    if (s_r) begin
                        hcnt_r  <= HCNT_W'(1);
                        state_r <= ST_HIGH;
                    end else if (gap_end_s) begin
                        latch_r  <= 1'b1;
                        error_r  <= (bitcnt_r != 5'd0);
                        lcnt_r   <= '0;
                        bitcnt_r <= 5'd0;
                        pixcnt_r <= '0;
                        shift_r  <= 24'd0;
                        state_r  <= ST_IDLE;
                    end else begin
                        lcnt_r <= lcnt_inc_s;
                    end
                end
                default: begin
                    state_r <= ST_WAIT_GAP;
                end
            endcase
        end
    end

    assign pixel_o       = pixel_r;
    assign pixel_idx_o   = pixel_idx_r;
    assign pixel_valid_o = pixel_valid_r;
    assign latch_o       = latch_r;
    assign error_o       = error_r;

`ifdef WS2812_RX_FORWARD_EN
    logic fwd_r;
    logic dout_r;
    logic last_pix_s;

    assign last_pix_s = (state_r == ST_HIGH) && !s_r && last_bit_s
                        && (pixcnt_r == PCNT_W'(LED_CNT - 1));

    // Forwarding opens after our last pixel and closes on the frame gap or an error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_r  <= 1'b0;
            dout_r <= 1'b0;
        end else begin
            dout_r <= s_r & fwd_r;
            if (hi_err_s || gap_end_s) begin
                fwd_r <= 1'b0;
            end else if (last_pix_s) begin
                fwd_r <= 1'b1;
            end else begin
                fwd_r <= fwd_r;
            end
        end
    end

    assign dout = dout_r;
`else
    assign dout = 1'b0;
`endif

endmodule
